// File: rtl/ring_code_monitor.sv
// Receive-side checker/decoder for a one-hot ring-counter bus: decodes, checks rotation, tracks lock.
// Define RING_MON_ERRCNT_EN to build the saturating error counter; otherwise err_count is tied to 0.
module ring_code_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             ring_in,
  input  logic                         ring_vld,
  output logic [$clog2(WIDTH)-1:0]     idx_out,
  output logic                         idx_vld,
  output logic                         locked,
  output logic                         onehot_err,
  output logic                         seq_err,
  output logic                         wrap_pulse,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             idx_vld_q, idx_vld_d;
  logic             locked_q, locked_d;
  logic             onehot_err_q, onehot_err_d;
  logic             seq_err_q, seq_err_d;
  logic             wrap_q, wrap_d;

  logic [PW-1:0]    pop_c;
  logic [IW-1:0]    enc_c;
  logic [WIDTH-1:0] expect_c;
  logic             rot_ok_c;
  logic [MW-1:0]    match_inc_c;

  // Popcount and binary encode of the incoming sample
  always_comb begin
    pop_c = '0;
    enc_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_c = pop_c + PW'(ring_in[i]);
      if (ring_in[i]) enc_c = IW'(i);
    end
  end

  assign expect_c    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign rot_ok_c    = (ring_in == expect_c);
  assign match_inc_c = match_cnt_q + MW'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    match_cnt_d  = match_cnt_q;
    idx_d        = idx_q;
    idx_vld_d    = 1'b0;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    wrap_d       = 1'b0;

    if (ring_vld) begin
      if (pop_c != PW'(1)) begin
        onehot_err_d = 1'b1;
        state_d      = HUNT;
        prev_d       = '0;
        match_cnt_d  = '0;
      end else begin
        idx_d     = enc_c;
        idx_vld_d = 1'b1;
        prev_d    = ring_in;
        case (state_q)
          HUNT: begin
            state_d     = TRACK;
            match_cnt_d = '0;
          end
          TRACK: begin
            if (rot_ok_c) begin
              if (match_inc_c == MW'(LOCK_CNT)) begin
                state_d     = LOCKED;
                match_cnt_d = '0;
              end else begin
                match_cnt_d = match_inc_c;
              end
            end else begin
              seq_err_d   = 1'b1;
              match_cnt_d = '0;
            end
          end
          LOCKED: begin
            if (rot_ok_c) begin
              wrap_d = prev_q[WIDTH-1] & ring_in[0];
            end else begin
              seq_err_d   = 1'b1;
              state_d     = TRACK;
              match_cnt_d = '0;
            end
          end
          default: begin
            state_d     = HUNT;
            match_cnt_d = '0;
          end
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      idx_q        <= '0;
      idx_vld_q    <= 1'b0;
      locked_q     <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_cnt_q  <= match_cnt_d;
      idx_q        <= idx_d;
      idx_vld_q    <= idx_vld_d;
      locked_q     <= locked_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      wrap_q       <= wrap_d;
    end
  end

`ifdef RING_MON_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Each bad sample adds one; the counter sticks at all-ones
  always_comb begin
    err_count_d = err_count_q;
    if ((onehot_err_d | seq_err_d) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign idx_out    = idx_q;
  assign idx_vld    = idx_vld_q;
  assign locked     = locked_q;
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_ring_code_monitor.sv
// Scoreboard bench for ring_code_monitor (WIDTH=4, LOCK_CNT=2, ERR_CNT_W=8) with directed vectors.
module tb_ring_code_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ring_in = 4'b0000;
  logic       ring_vld = 1'b0;
  logic [1:0] idx_out;
  logic       idx_vld, locked, onehot_err, seq_err, wrap_pulse;
  logic [7:0] err_count;

  typedef struct {
    logic [1:0] idx;
    logic       ivld;
    logic       lock;
    logic       oh;
    logic       seq;
    logic       wrap;
    logic [7:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  ring_code_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ring_in    (ring_in),
    .ring_vld   (ring_vld),
    .idx_out    (idx_out),
    .idx_vld    (idx_vld),
    .locked     (locked),
    .onehot_err (onehot_err),
    .seq_err    (seq_err),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per issued cycle, compared just after the capturing edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("idx_out",    8'(idx_out),    8'(e.idx));
      chk("idx_vld",    8'(idx_vld),    8'(e.ivld));
      chk("locked",     8'(locked),     8'(e.lock));
      chk("onehot_err", 8'(onehot_err), 8'(e.oh));
      chk("seq_err",    8'(seq_err),    8'(e.seq));
      chk("wrap_pulse", 8'(wrap_pulse), 8'(e.wrap));
      chk("err_count",  err_count,      e.err);
    end
  end

  // err is the value with the counter built; it collapses to 0 otherwise
  task automatic step(input logic rst, input logic vld, input logic [3:0] r,
                      input logic [1:0] idx, input logic ivld, input logic lock,
                      input logic oh, input logic seq, input logic wrap,
                      input logic [7:0] err);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    ring_vld = vld;
    ring_in  = r;
    e.idx  = idx;
    e.ivld = ivld;
    e.lock = lock;
    e.oh   = oh;
    e.seq  = seq;
    e.wrap = wrap;
`ifdef RING_MON_ERRCNT_EN
    e.err  = err;
`else
    e.err  = 8'd0;
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    // reset state
    step(1, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0, 8'd0);
    // acquire lock
    step(0, 1, 4'b0001, 2'd0, 1, 0, 0, 0, 0, 8'd0);
    step(0, 1, 4'b0010, 2'd1, 1, 0, 0, 0, 0, 8'd0);
    step(0, 1, 4'b0100, 2'd2, 1, 1, 0, 0, 0, 8'd0);
    // wrap while locked
    step(0, 1, 4'b1000, 2'd3, 1, 1, 0, 0, 0, 8'd0);
    step(0, 1, 4'b0001, 2'd0, 1, 1, 0, 0, 1, 8'd0);
    // stalled counter
    step(0, 1, 4'b0010, 2'd1, 1, 1, 0, 0, 0, 8'd0);
    step(0, 1, 4'b0010, 2'd1, 1, 0, 0, 1, 0, 8'd1);
    step(0, 1, 4'b0100, 2'd2, 1, 0, 0, 0, 0, 8'd1);
    step(0, 1, 4'b1000, 2'd3, 1, 1, 0, 0, 0, 8'd1);
    // illegal code while locked, then reacquire without seq_err
    step(0, 1, 4'b0110, 2'd3, 0, 0, 1, 0, 0, 8'd2);
    step(0, 1, 4'b0001, 2'd0, 1, 0, 0, 0, 0, 8'd2);
    // ring_vld low holds everything
    step(0, 0, 4'b0001, 2'd0, 0, 0, 0, 0, 0, 8'd2);
    step(0, 1, 4'b0010, 2'd1, 1, 0, 0, 0, 0, 8'd2);
    step(0, 0, 4'b0001, 2'd1, 0, 0, 0, 0, 0, 8'd2);
    // reset beats a concurrent illegal sample
    step(1, 1, 4'b0000, 2'd0, 0, 0, 0, 0, 0, 8'd0);
    // saturation of the error counter
    for (int k = 1; k <= 300; k++) begin
      step(0, 1, (k % 2 == 1) ? 4'b0000 : 4'b1111, 2'd0, 0, 0, 1, 0, 0,
           (k > 255) ? 8'd255 : 8'(k));
    end
    // lock again, then a wrong jump while locked stays saturated
    step(0, 1, 4'b0001, 2'd0, 1, 0, 0, 0, 0, 8'd255);
    step(0, 1, 4'b0010, 2'd1, 1, 0, 0, 0, 0, 8'd255);
    step(0, 1, 4'b0100, 2'd2, 1, 1, 0, 0, 0, 8'd255);
    step(0, 1, 4'b0001, 2'd0, 1, 0, 0, 1, 0, 8'd255);
    step(0, 0, 4'b0000, 2'd0, 0, 0, 0, 0, 0, 8'd255);

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
